// File: rtl/pc_source_ctrl_pkg.sv
// Shared definitions for the PC-source control slice: FSM state encoding,
// PC source mux select codes, exception cause codes and the default
// exception vector addresses.
package pc_source_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXC_SAVE = 2'd1,
    ST_EXC_READ = 2'd2,
    ST_EXC_LOAD = 2'd3
  } state_t;

  // PC source mux selects
  localparam logic [2:0] SRC_JUMP   = 3'd0;
  localparam logic [2:0] SRC_RESULT = 3'd1;
  localparam logic [2:0] SRC_ALUOUT = 3'd2;
  localparam logic [2:0] SRC_MEM    = 3'd3;
  localparam logic [2:0] SRC_EPC    = 3'd4;

  // exception cause codes
  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_DIV0   = 2'd3;

  // default handler vectors
  localparam logic [31:0] VEC_OPCODE_DEF = 32'd253;
  localparam logic [31:0] VEC_OVF_DEF    = 32'd254;
  localparam logic [31:0] VEC_DIV0_DEF   = 32'd255;
  localparam logic [31:0] EPC_OFFSET_DEF = 32'd4;

endpackage

// File: rtl/pc_source_ctrl_exc_prio_enc.sv
// Combinational exception cause priority encoder.
// Ports:
//   exc_opcode/exc_ovf/exc_div0 : exception pulses
//   cause : winning cause code (opcode > ovf > div0), CAUSE_NONE if idle
//   vec   : handler vector address for the winning cause
//   any   : at least one pulse present
module exc_prio_enc
  import pc_source_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF
) (
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  output logic [1:0]  cause,
  output logic [31:0] vec,
  output logic        any
);

  always_comb begin
    cause = CAUSE_NONE;
    vec   = '0;
    if (exc_opcode) begin
      cause = CAUSE_OPCODE;
      vec   = VEC_OPCODE;
    end else if (exc_ovf) begin
      cause = CAUSE_OVF;
      vec   = VEC_OVF;
    end else if (exc_div0) begin
      cause = CAUSE_DIV0;
      vec   = VEC_DIV0;
    end
  end

  assign any = exc_opcode | exc_ovf | exc_div0;

endmodule

// File: rtl/pc_source_ctrl.sv
// PC source select / PC write strobe generator with exception entry
// sequencing (save EPC, fetch handler vector, load PC) and return from
// exception.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   req_valid/src   : PC update request from main control (src 0..2 legal)
//   exc_*           : exception pulses
//   rte             : return from exception
//   pc_cur          : current PC value
//   pc_source       : PC source mux select (held between strobes)
//   pc_write        : one-cycle PC load strobe
//   mem_addr/read   : handler vector fetch
//   epc, exc_cause  : saved PC and last taken cause
//   busy            : exception sequence in progress
module pc_source_ctrl
  import pc_source_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF,
  parameter logic [31:0] EPC_OFFSET = EPC_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_src,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic        rte,
  input  logic [31:0] pc_cur,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic [31:0] epc,
  output logic [1:0]  exc_cause,
  output logic        busy
);

  localparam int CW = $clog2(MEM_LAT) + 1;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0] vec_q, vec_nxt;
  logic [2:0]  pc_source_nxt;
  logic        pc_write_nxt, mem_read_nxt, busy_nxt;
  logic [31:0] mem_addr_nxt, epc_nxt;
  logic [1:0]  cause_nxt;

  logic [1:0]  enc_cause;
  logic [31:0] enc_vec;
  logic        enc_any;

  exc_prio_enc #(
    .VEC_OPCODE (VEC_OPCODE),
    .VEC_OVF    (VEC_OVF),
    .VEC_DIV0   (VEC_DIV0)
  ) u_enc (
    .exc_opcode (exc_opcode),
    .exc_ovf    (exc_ovf),
    .exc_div0   (exc_div0),
    .cause      (enc_cause),
    .vec        (enc_vec),
    .any        (enc_any)
  );

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      vec_q     <= '0;
      pc_source <= SRC_JUMP;
      pc_write  <= 1'b0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      epc       <= '0;
      exc_cause <= CAUSE_NONE;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      vec_q     <= vec_nxt;
      pc_source <= pc_source_nxt;
      pc_write  <= pc_write_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_read  <= mem_read_nxt;
      epc       <= epc_nxt;
      exc_cause <= cause_nxt;
      busy      <= busy_nxt;
    end
  end

  // next state; cnt counts remaining EXC_READ cycles after the current one
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE:     if (enc_any) state_nxt = ST_EXC_SAVE;
      ST_EXC_SAVE: begin
        state_nxt = ST_EXC_READ;
        cnt_nxt   = CW'(MEM_LAT - 1);
      end
      ST_EXC_READ: begin
        if (cnt == '0) state_nxt = ST_EXC_LOAD;
        else           cnt_nxt   = cnt - CW'(1);
      end
      ST_EXC_LOAD: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // next values of the registered outputs; pc_source holds unless strobed
  always_comb begin
    pc_source_nxt = pc_source;
    pc_write_nxt  = 1'b0;
    mem_addr_nxt  = mem_addr;
    epc_nxt       = epc;
    cause_nxt     = exc_cause;
    vec_nxt       = vec_q;
    mem_read_nxt  = (state_nxt == ST_EXC_READ);
    busy_nxt      = (state_nxt != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (enc_any) begin
          epc_nxt   = pc_cur - EPC_OFFSET;
          cause_nxt = enc_cause;
          vec_nxt   = enc_vec;
        end else if (rte) begin
          pc_source_nxt = SRC_EPC;
          pc_write_nxt  = 1'b1;
        end else if (req_valid && req_src <= SRC_ALUOUT) begin
          pc_source_nxt = req_src;
          pc_write_nxt  = 1'b1;
        end
      end
      ST_EXC_SAVE: mem_addr_nxt = vec_q;
      ST_EXC_READ: begin
        if (state_nxt == ST_EXC_LOAD) begin
          pc_source_nxt = SRC_MEM;
          pc_write_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_source_ctrl.sv
module tb_pc_source_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_src;
  logic        exc_opcode, exc_ovf, exc_div0, rte;
  logic [31:0] pc_cur;

  logic [2:0]  o1_src,   o3_src;
  logic        o1_wr,    o3_wr;
  logic [31:0] o1_maddr, o3_maddr;
  logic        o1_mrd,   o3_mrd;
  logic [31:0] o1_epc,   o3_epc;
  logic [1:0]  o1_cause, o3_cause;
  logic        o1_busy,  o3_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_source_ctrl #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_src(req_src),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .rte(rte), .pc_cur(pc_cur), .pc_source(o1_src), .pc_write(o1_wr),
    .mem_addr(o1_maddr), .mem_read(o1_mrd), .epc(o1_epc),
    .exc_cause(o1_cause), .busy(o1_busy));

  pc_source_ctrl #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_src(req_src),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .rte(rte), .pc_cur(pc_cur), .pc_source(o3_src), .pc_write(o3_wr),
    .mem_addr(o3_maddr), .mem_read(o3_mrd), .epc(o3_epc),
    .exc_cause(o3_cause), .busy(o3_busy));

  // Reference: an accepted exception starts a schedule indexed by 'age'
  // (cycles since acceptance): 1 = save, 2..1+lat = vector read,
  // 2+lat = PC load. age 0 means idle and accepting requests.
  typedef struct {
    int          age;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] vec;
    logic [2:0]  src;
    logic        wr;
    logic [31:0] maddr;
  } mdl_t;

  mdl_t m1, m3;

  function automatic mdl_t mdl_step(input mdl_t m, input int lat);
    mdl_t n = m;
    if (!reset) begin
      n = '{0, 32'd0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0};
      return n;
    end
    n.wr = 1'b0;
    if (m.age > 0) begin
      n.age = m.age + 1;
      if (n.age > 2 + lat) n.age = 0;
    end else if (exc_opcode || exc_ovf || exc_div0) begin
      n.age   = 1;
      n.cause = exc_opcode ? 2'd1 : exc_ovf ? 2'd2 : 2'd3;
      n.vec   = 32'd252 + 32'(n.cause);
      n.epc   = pc_cur - 32'd4;
    end else if (rte) begin
      n.wr  = 1'b1;
      n.src = 3'd4;
    end else if (req_valid && req_src <= 3'd2) begin
      n.wr  = 1'b1;
      n.src = req_src;
    end
    if (n.age == 2 + lat) begin
      n.wr  = 1'b1;
      n.src = 3'd3;
    end
    if (n.age >= 2 && n.age <= 1 + lat) n.maddr = n.vec;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(input int lat);
    mdl_t m = (lat == 1) ? m1 : m3;
    if (lat == 1) begin
      chk("d1.pc_source", 32'(o1_src),   32'(m.src));
      chk("d1.pc_write",  32'(o1_wr),    32'(m.wr));
      chk("d1.mem_addr",  o1_maddr,      m.maddr);
      chk("d1.mem_read",  32'(o1_mrd),   32'(m.age >= 2 && m.age <= 1 + lat));
      chk("d1.epc",       o1_epc,        m.epc);
      chk("d1.exc_cause", 32'(o1_cause), 32'(m.cause));
      chk("d1.busy",      32'(o1_busy),  32'(m.age != 0));
    end else begin
      chk("d3.pc_source", 32'(o3_src),   32'(m.src));
      chk("d3.pc_write",  32'(o3_wr),    32'(m.wr));
      chk("d3.mem_addr",  o3_maddr,      m.maddr);
      chk("d3.mem_read",  32'(o3_mrd),   32'(m.age >= 2 && m.age <= 1 + lat));
      chk("d3.epc",       o3_epc,        m.epc);
      chk("d3.exc_cause", 32'(o3_cause), 32'(m.cause));
      chk("d3.busy",      32'(o3_busy),  32'(m.age != 0));
    end
  endtask

  // one clock: advance models with the inputs seen at the edge, then check
  task automatic step();
    @(posedge clk);
    m1 = mdl_step(m1, 1);
    m3 = mdl_step(m3, 3);
    #1;
    cmp_all(1);
    cmp_all(3);
  endtask

  task automatic drv(input logic rst, input logic rv, input logic [2:0] src,
                     input logic eo, input logic ev, input logic ed,
                     input logic rt, input logic [31:0] pc);
    reset = rst; req_valid = rv; req_src = src;
    exc_opcode = eo; exc_ovf = ev; exc_div0 = ed; rte = rt; pc_cur = pc;
  endtask

  task automatic idle(input int n);
    drv(1, 0, 0, 0, 0, 0, 0, 32'h100);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int rd_cnt;
    m1 = '{0, 32'd0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0};
    m3 = m1;
    drv(1, 0, 0, 0, 0, 0, 0, 0);

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drv(0, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), $urandom);
      step();
    end
    chk("rst.busy", 32'(o1_busy), 0);
    chk("rst.epc",  o1_epc, 0);
    idle(1);

    // 2: pass-through
    drv(1, 1, 3'd2, 0, 0, 0, 0, 32'h100);
    step();
    chk("pass.src2", 32'(o1_src), 2);
    chk("pass.wr",   32'(o1_wr), 1);
    drv(1, 1, 3'd5, 0, 0, 0, 0, 32'h100);
    step();
    chk("pass.src5.wr", 32'(o1_wr), 0);
    idle(1);

    // 3: overflow, MEM_LAT=1
    drv(1, 0, 0, 0, 1, 0, 0, 32'h40);
    step();
    chk("ovf.epc",   o1_epc, 32'h3C);
    chk("ovf.cause", 32'(o1_cause), 2);
    chk("ovf.busy1", 32'(o1_busy), 1);
    idle(1);
    chk("ovf.maddr", o1_maddr, 32'd254);
    chk("ovf.mrd",   32'(o1_mrd), 1);
    idle(1);
    chk("ovf.src3",  32'(o1_src), 3);
    chk("ovf.wr",    32'(o1_wr), 1);
    chk("ovf.busy3", 32'(o1_busy), 1);
    idle(1);
    chk("ovf.done",  32'(o1_busy), 0);
    idle(4);

    // 5: rte, then rte together with an exception
    drv(1, 0, 0, 0, 0, 0, 1, 32'h200);
    step();
    chk("rte.src", 32'(o1_src), 4);
    chk("rte.wr",  32'(o1_wr), 1);
    chk("rte.epc", o1_epc, 32'h3C);
    drv(1, 0, 0, 0, 1, 0, 1, 32'h80);
    step();
    chk("rte_exc.busy", 32'(o1_busy), 1);
    chk("rte_exc.epc",  o1_epc, 32'h7C);
    idle(6);

    // 4: simultaneous causes, then a pulse while busy
    drv(1, 0, 0, 1, 0, 1, 0, 32'h1000);
    step();
    chk("sim.cause", 32'(o1_cause), 1);
    drv(1, 0, 0, 0, 0, 1, 0, 32'h2000);
    step();
    chk("sim.maddr", o1_maddr, 32'd253);
    chk("sim.epc",   o1_epc, 32'hFFC);
    idle(6);

    // 6: pc_cur=0, MEM_LAT=3 read length, reset during read
    drv(1, 0, 0, 0, 0, 1, 0, 32'h0);
    step();
    chk("wrap.epc", o3_epc, 32'hFFFF_FFFC);
    rd_cnt = 0;
    drv(1, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (o3_mrd) rd_cnt++;
    end
    chk("lat3.mrd_cycles", 32'(rd_cnt), 3);
    idle(2);
    drv(1, 0, 0, 0, 1, 0, 0, 32'h500);
    step();
    idle(2);
    chk("midrst.pre", 32'(o3_mrd), 1);
    drv(0, 0, 0, 0, 0, 0, 0, 32'h0);
    step();
    chk("midrst.busy", 32'(o3_busy), 0);
    chk("midrst.epc",  o3_epc, 0);
    idle(1);

    // randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      drv(($urandom_range(0, 99) != 0), 1'($urandom), 3'($urandom),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
